// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the double-dabble binary to BCD converter.
// Optional leading-zero blanking is enabled with BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH  = 13;
  localparam int unsigned DEF_DIGITS = 4;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_WIDTH + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Add-3 correction cell for one BCD scratch digit.
// Result is truncated to 4 bits; part of the BIN2BCD_BLANK_EN-capable converter.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter with registered BCD result and done pulse.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero mask port.
module bin_to_bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch_q[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_pend_d = (64'(bin) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {scratch_adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Saturate so an out-of-range input still shows legal digits
        bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;

  // Digit 0 is never blanked so a zero value still shows one "0"
  always_comb begin
    blank_d  = blank_q;
    zero_run = 1'b1;
    if (done_d) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_run   = zero_run & (bcd_d[4*i +: 4] == 4'h0);
        blank_d[i] = zero_run;
      end
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench: default-size converter plus a WIDTH=14 instance for saturation.
// Blank checks are active when BIN2BCD_BLANK_EN is defined.
module tb_bin_to_bcd_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, ovf_a;
  logic [12:0] bin_a;
  logic [15:0] bcd_a;
  logic        rst_b, start_b, busy_b, done_b, ovf_b;
  logic [13:0] bin_b;
  logic [15:0] bcd_b;
  logic [3:0]  blank_a, blank_b;

  bin_to_bcd_converter #(.WIDTH(13), .DIGITS(4)) u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .start (start_a),
    .bin   (bin_a),
    .busy  (busy_a),
    .done  (done_a),
    .bcd   (bcd_a),
    .ovf   (ovf_a)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank_a)
`endif
  );

  bin_to_bcd_converter #(.WIDTH(14), .DIGITS(4)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .start (start_b),
    .bin   (bin_b),
    .busy  (busy_b),
    .done  (done_b),
    .bcd   (bcd_b),
    .ovf   (ovf_b)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank_b)
`endif
  );

`ifndef BIN2BCD_BLANK_EN
  assign blank_a = 4'b0000;
  assign blank_b = 4'b0000;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal arithmetic and a latency countdown
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10),
            4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    int s;
    logic [3:0] b;
    s = (v > 9999) ? 9999 : v;
    b[0] = 1'b0;
    b[1] = (s < 10);
    b[2] = (s < 100);
    b[3] = (s < 1000);
    return b;
  endfunction

  int          m_cnt[2]   = '{0, 0};
  int          m_val[2]   = '{0, 0};
  int          m_w[2]     = '{13, 14};
  logic [15:0] m_bcd[2]   = '{16'h0, 16'h0};
  logic [3:0]  m_blank[2] = '{4'b1110, 4'b1110};
  logic        m_ovf[2]   = '{1'b0, 1'b0};
  logic        m_done[2]  = '{1'b0, 1'b0};
  logic        m_busy[2]  = '{1'b0, 1'b0};

  task automatic model_step(input int k, input logic r, input logic s,
                            input int v);
    if (r) begin
      m_cnt[k] = 0; m_bcd[k] = 16'h0; m_ovf[k] = 1'b0;
      m_done[k] = 1'b0; m_busy[k] = 1'b0; m_blank[k] = 4'b1110;
    end else begin
      m_done[k] = 1'b0;
      if (m_cnt[k] == 0) begin
        if (s) begin
          m_val[k] = v; m_cnt[k] = m_w[k] + 1; m_busy[k] = 1'b1;
        end
      end else begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_bcd[k]   = ref_bcd(m_val[k]);
          m_blank[k] = ref_blank(m_val[k]);
          m_ovf[k]   = (m_val[k] > 9999);
          m_done[k]  = 1'b1;
          m_busy[k]  = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, start_a, int'(bin_a));
    model_step(1, rst_b, start_b, int'(bin_b));
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("a_done", done_a, m_done[0]);
      chk("a_busy", busy_a, m_busy[0]);
      chk("a_bcd", bcd_a, m_bcd[0]);
      chk("a_ovf", ovf_a, m_ovf[0]);
      chk("b_done", done_b, m_done[1]);
      chk("b_busy", busy_b, m_busy[1]);
      chk("b_bcd", bcd_b, m_bcd[1]);
      chk("b_ovf", ovf_b, m_ovf[1]);
`ifdef BIN2BCD_BLANK_EN
      chk("a_blank", blank_a, m_blank[0]);
      chk("b_blank", blank_b, m_blank[1]);
`endif
    end
  end

  // One conversion with literal expectations, measuring accept-to-done latency
  task automatic conv(input int k, input int v, input int exp_lat,
                      input logic [15:0] eb, input logic [3:0] ebl,
                      input logic eo);
    int n;
    n = 0;
    if (k == 0) begin
      bin_a = 13'(v); start_a = 1'b1;
    end else begin
      bin_b = 14'(v); start_b = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    repeat (40) begin
      @(negedge clk);
      n++;
      if ((k == 0) ? done_a : done_b) break;
    end
    chk($sformatf("lat_%0d", v), n, exp_lat);
    chk($sformatf("bcd_%0d", v), (k == 0) ? bcd_a : bcd_b, eb);
    chk($sformatf("ovf_%0d", v), (k == 0) ? ovf_a : ovf_b, eo);
`ifdef BIN2BCD_BLANK_EN
    chk($sformatf("blank_%0d", v), (k == 0) ? blank_a : blank_b, ebl);
`endif
    if (ebl === 4'bxxxx) n = 0;
    @(negedge clk);
    chk($sformatf("pulse_%0d", v), (k == 0) ? done_a : done_b, 1'b0);
  endtask

  initial begin
    int seen;
    int gap;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b1; start_b = 1'b1;
    bin_a = 13'd0; bin_b = 14'd0;
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcd", bcd_a, 16'h0000);
    chk("rst_ovf", ovf_a, 1'b0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_blank", blank_a, 4'b1110);
`endif
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);

    conv(0, 1234, 14, 16'h1234, 4'b0000, 1'b0);
    conv(0, 7,    14, 16'h0007, 4'b1110, 1'b0);
    conv(0, 0,    14, 16'h0000, 4'b1110, 1'b0);
    conv(0, 8191, 14, 16'h8191, 4'b0000, 1'b0);

    // Second request during SHIFT must be dropped
    bin_a = 13'd42; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    bin_a = 13'd999; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) begin
        seen++;
        if (seen == 1) chk("drop_bcd", bcd_a, 16'h0042);
      end
    end
    chk("drop_count", seen, 1);
    chk("drop_hold", bcd_a, 16'h0042);

    // Reset in the middle of a conversion
    bin_a = 13'd5555; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_bcd", bcd_a, 16'h0000);
    conv(0, 12, 14, 16'h0012, 4'b1100, 1'b0);

    conv(1, 12345, 15, 16'h9999, 4'b0000, 1'b1);
    conv(1, 9999,  15, 16'h9999, 4'b0000, 1'b0);

    // Back-to-back conversions with start held high
    bin_b = 14'd100; start_b = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_b) begin seen = 1; break; end
    end
    chk("b2b_first", seen, 1);
    gap = 0;
    repeat (40) begin
      @(negedge clk);
      gap++;
      if (done_b) break;
    end
    chk("b2b_gap", gap, 16);
    chk("b2b_bcd", bcd_b, 16'h0100);
    start_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential double-dabble converter turning an unsigned binary value into packed BCD digits for the four-digit seven-segment display path. It sits directly upstream of the display driver: it samples a value from the processor debug/readout path on a start strobe and produces a stable, registered BCD word plus a completion pulse. Using this block removes the wide combinational divide/modulo chain from the display path.

## Interface
- WIDTH, 13, bit width of the binary input
- DIGITS, 4, number of BCD output digits
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  request a conversion; sampled only in IDLE
- bin  in  WIDTH  unsigned value; captured on the accepting edge
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse; bcd and ovf are valid and updated
- bcd  out  4*DIGITS  packed result, digit 0 in [3:0]; holds until the next done
- ovf  out  1  high when the last input exceeded 10^DIGITS-1
- blank  out  DIGITS  leading-zero mask, one bit per digit (present only with BIN2BCD_BLANK_EN)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1, capture bin into the shift register, clear the BCD scratch, load the iteration counter with WIDTH, and compare bin against 10^DIGITS-1 into the pending ovf. Next state is SHIFT.
- SHIFT: each cycle, apply the add-3 correction to every scratch digit ≥5, then shift {scratch, shift} left by 1 and decrement the counter. After the WIDTH-th shift, go to DONE.
- DONE: register the scratch into bcd, or all 9s if the pending ovf is set. Register ovf. Assert done for this cycle. Next state is IDLE.
- start is ignored in SHIFT and DONE; no queuing.
- Scratch digits are 4 bits each. The correction is digit+3 truncated to 4 bits. A digit value above 9 never appears in the registered bcd.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, ovf=0, blank={(DIGITS-1){1}, 0}.
- rst mid-conversion aborts the conversion on the next edge: no done, and bcd is cleared.
- With the defaults, ovf can never assert (8191 < 9999). The saturation path exists for parameter sets where WIDTH exceeds the digit capacity.

## Timing
- Edge N accepts start. Edges N+1..N+WIDTH perform the shifts. done is high in the cycle after edge N+WIDTH+1.
- Latency from the accepting edge to done is WIDTH+1 cycles (14 with defaults).
- bcd, ovf and blank change only on the edge that raises done. They are stable in every other cycle, so they are safe for the display driver to read asynchronously to done.
- Throughput with start held high is one result every WIDTH+2 cycles (15 with defaults). The next accept happens in the IDLE cycle after DONE.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - The blank port exists and is registered together with bcd.
  - blank[i]=1 when digit i and every higher digit are zero.
  - blank[0] is always 0, so a value of 0 shows a single "0".
- Undefined: the blank port and its logic are absent. All other behaviour is identical.

## Structure
- Package bin2bcd_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - function pow10(n), used for the 10^DIGITS-1 overflow bound;
  - a localparam for the counter width, $clog2(WIDTH+1).
- Sub-module bcd_digit_adjust: a combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times inside the SHIFT datapath.

## Test plan
- Reset: hold rst high 2 cycles with start=1 → busy=0, done=0, bcd=16'h0000, ovf=0, blank=4'b1110.
- bin=1234 with a 1-cycle start → done exactly 14 cycles after accept, bcd=16'h1234, ovf=0, blank=4'b0000; done high for exactly 1 cycle.
- bin=7, then bin=0, then bin=8191 → bcd=16'h0007 (blank 4'b1110), 16'h0000 (blank 4'b1110), 16'h8191 (blank 4'b0000).
- Start with bin=42, then pulse start with bin=999 at accept+5 → a single done with bcd=16'h0042; the second request is dropped.
- Start with bin=5555, assert rst at accept+6 for 1 cycle → no done, bcd=0; a subsequent start with bin=12 gives bcd=16'h0012.
- WIDTH=14, DIGITS=4, bin=12345 → ovf=1, bcd=16'h9999; then bin=9999 → ovf=0, bcd=16'h9999. With start held high, back-to-back dones are spaced 16 cycles apart.
